// File: rtl/interval_shape_scan.sv
// Scan-line interval generator: for a requested line y, streams one clipped [s, t]
// span per shape descriptor (square, rectangle, diamond) over a valid/ready handshake.
module interval_shape_scan #(
    parameter int CORDW      = 9,
    parameter int NSHAPE     = 8,
    parameter int IDW        = $clog2(NSHAPE),
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDW-1:0]   cfg_id,
    input  logic             cfg_en,
    input  logic [1:0]       cfg_mode,
    input  logic [CORDW-1:0] cfg_x0,
    input  logic [CORDW-1:0] cfg_y0,
    input  logic [CORDW-1:0] cfg_w,
    input  logic [CORDW-1:0] cfg_h,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CORDW-1:0] req_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDW-1:0]   out_id,
    output logic [CORDW-1:0] out_s,
    output logic [CORDW-1:0] out_t,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [IDW-1:0]   LAST_ID = IDW'(NSHAPE - 1);
    localparam logic [IDW-1:0]   ID_ONE  = IDW'(1);
    localparam logic [IDW-1:0]   ID_ZERO = IDW'(0);
    localparam logic [CORDW-1:0] ZERO_C  = {CORDW{1'b0}};
    localparam logic [CORDW-1:0] ONE_C   = {{(CORDW-1){1'b0}}, 1'b1};
    localparam logic [CORDW-1:0] MAX_C   = {CORDW{1'b1}};

    function automatic logic [CORDW-1:0] sat_add(input logic [CORDW-1:0] a,
                                                 input logic [CORDW-1:0] b);
        logic [CORDW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CORDW]) begin
            sat_add = MAX_C;
        end else begin
            sat_add = sum[CORDW-1:0];
        end
    endfunction

    function automatic logic [CORDW-1:0] clamp_sub(input logic [CORDW-1:0] a,
                                                   input logic [CORDW-1:0] b);
        logic [CORDW:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[CORDW]) begin
            clamp_sub = ZERO_C;
        end else begin
            clamp_sub = diff[CORDW-1:0];
        end
    endfunction

    logic             tbl_en_r   [NSHAPE];
    logic [1:0]       tbl_mode_r [NSHAPE];
    logic [CORDW-1:0] tbl_x0_r   [NSHAPE];
    logic [CORDW-1:0] tbl_y0_r   [NSHAPE];
    logic [CORDW-1:0] tbl_w_r    [NSHAPE];
    logic [CORDW-1:0] tbl_h_r    [NSHAPE];

    state_t           state_r;
    logic [IDW-1:0]   idx_r;
    logic [CORDW-1:0] y_r;
    logic             busy_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [IDW-1:0]   out_id_r;
    logic [CORDW-1:0] out_s_r;
    logic [CORDW-1:0] out_t_r;

    logic             cur_en_s;
    logic [1:0]       cur_mode_s;
    logic [CORDW-1:0] cur_x0_s;
    logic [CORDW-1:0] cur_y0_s;
    logic [CORDW-1:0] cur_w_s;
    logic [CORDW-1:0] cur_h_s;
    logic [CORDW-1:0] vbound_s;
    logic [CORDW-1:0] dist_s;
    logic [CORDW-1:0] ext_s;
    logic             ev_empty_s;
    logic [CORDW-1:0] ev_s_s;
    logic [CORDW-1:0] ev_t_s;

    // Descriptor table: cleared by reset, writable only while no scan is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSHAPE; i++) begin
                tbl_en_r[i]   <= 1'b0;
                tbl_mode_r[i] <= 2'd0;
                tbl_x0_r[i]   <= ZERO_C;
                tbl_y0_r[i]   <= ZERO_C;
                tbl_w_r[i]    <= ZERO_C;
                tbl_h_r[i]    <= ZERO_C;
            end
        end else if (cfg_we && !busy_r) begin
            tbl_en_r[cfg_id]   <= cfg_en;
            tbl_mode_r[cfg_id] <= cfg_mode;
            tbl_x0_r[cfg_id]   <= cfg_x0;
            tbl_y0_r[cfg_id]   <= cfg_y0;
            tbl_w_r[cfg_id]    <= cfg_w;
            tbl_h_r[cfg_id]    <= cfg_h;
        end
    end

    // Interval of the current entry against the latched line; empty is s=1, t=0.
    always_comb begin
        cur_en_s   = tbl_en_r[idx_r];
        cur_mode_s = tbl_mode_r[idx_r];
        cur_x0_s   = tbl_x0_r[idx_r];
        cur_y0_s   = tbl_y0_r[idx_r];
        cur_w_s    = tbl_w_r[idx_r];
        cur_h_s    = tbl_h_r[idx_r];
        vbound_s   = sat_add(cur_y0_s, (cur_mode_s == 2'd1) ? cur_h_s : cur_w_s);
        dist_s     = (y_r >= cur_y0_s) ? (y_r - cur_y0_s) : (cur_y0_s - y_r);
        ext_s      = cur_w_s - dist_s;
        ev_empty_s = 1'b1;
        ev_s_s     = ONE_C;
        ev_t_s     = ZERO_C;
        case (cur_mode_s)
            2'd0, 2'd1: begin
                if (cur_en_s && (y_r >= cur_y0_s) && (y_r <= vbound_s)) begin
                    ev_empty_s = 1'b0;
                    ev_s_s     = cur_x0_s;
                    ev_t_s     = sat_add(cur_x0_s, cur_w_s);
                end else begin
                    ev_empty_s = 1'b1;
                end
            end
            2'd2: begin
                if (cur_en_s && (dist_s <= cur_w_s)) begin
                    ev_empty_s = 1'b0;
                    ev_s_s     = clamp_sub(cur_x0_s, ext_s);
                    ev_t_s     = sat_add(cur_x0_s, ext_s);
                end else begin
                    ev_empty_s = 1'b1;
                end
            end
            default: begin
                ev_empty_s = 1'b1;
            end
        endcase
    end

    // Scan sequencer with registered result beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            idx_r       <= ID_ZERO;
            y_r         <= ZERO_C;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_id_r    <= ID_ZERO;
            out_s_r     <= ONE_C;
            out_t_r     <= ZERO_C;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        y_r     <= req_y;
                        idx_r   <= ID_ZERO;
                        state_r <= ST_EVAL;
                        busy_r  <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (ev_empty_s && SKIP_EMPTY && (idx_r != LAST_ID)) begin
                        idx_r <= idx_r + ID_ONE;
                    end else begin
                        out_valid_r <= 1'b1;
                        out_id_r    <= idx_r;
                        out_s_r     <= ev_s_s;
                        out_t_r     <= ev_t_s;
                        out_last_r  <= (idx_r == LAST_ID);
                        state_r     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (idx_r == LAST_ID) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            idx_r   <= idx_r + ID_ONE;
                            state_r <= ST_EVAL;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is masked by rst so it reads 0 during the reset cycle itself.
    assign req_ready = !busy_r && !rst;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_id    = out_id_r;
    assign out_s     = out_s_r;
    assign out_t     = out_t_r;

endmodule

// File: tb/tb_interval_shape_scan.sv
// Bench: two instances (skipping / non-skipping) driven in lockstep, checked every cycle
// against a descriptor-level scan model, plus literal beat lists from hand calculation.
module tb_interval_shape_scan;

    localparam int CMAX = 511;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cfg_we, cfg_en, req_valid, out_ready;
    logic [1:0] cfg_id, cfg_mode;
    logic [8:0] cfg_x0, cfg_y0, cfg_w, cfg_h, req_y;

    logic [1:0]       req_ready_v, out_valid_v, out_last_v, busy_v;
    logic [1:0][1:0]  out_id_v;
    logic [1:0][8:0]  out_s_v, out_t_v;

    interval_shape_scan #(.CORDW(9), .NSHAPE(4), .IDW(2), .SKIP_EMPTY(1'b1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_en(cfg_en),
        .cfg_mode(cfg_mode), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .req_valid(req_valid), .req_ready(req_ready_v[0]), .req_y(req_y),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_id(out_id_v[0]),
        .out_s(out_s_v[0]), .out_t(out_t_v[0]), .out_last(out_last_v[0]), .busy(busy_v[0]));

    interval_shape_scan #(.CORDW(9), .NSHAPE(4), .IDW(2), .SKIP_EMPTY(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_en(cfg_en),
        .cfg_mode(cfg_mode), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .req_valid(req_valid), .req_ready(req_ready_v[1]), .req_y(req_y),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_id(out_id_v[1]),
        .out_s(out_s_v[1]), .out_t(out_t_v[1]), .out_last(out_last_v[1]), .busy(busy_v[1]));

    typedef struct {
        int id;
        int s;
        int t;
        int last;
    } beat_t;

    beat_t exq [2][$];
    beat_t logq[2][$];
    int    m_en[2][4], m_mode[2][4], m_x0[2][4], m_y0[2][4], m_w[2][4], m_h[2][4];
    bit    mbusy[2];
    bit    hold[2];
    beat_t held[2];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Geometric rule for one shape on one line; empty gives s=1, t=0.
    function automatic void model_iv(input int k, input int id, input int y,
                                     output bit emp, output int s, output int t);
        int top, d, e;
        emp = 1'b1; s = 1; t = 0;
        if (m_en[k][id] != 0 && m_mode[k][id] <= 1) begin
            top = m_y0[k][id] + ((m_mode[k][id] == 1) ? m_h[k][id] : m_w[k][id]);
            if (top > CMAX) top = CMAX;
            if (y >= m_y0[k][id] && y <= top) begin
                emp = 1'b0;
                s = m_x0[k][id];
                t = m_x0[k][id] + m_w[k][id];
                if (t > CMAX) t = CMAX;
            end
        end else if (m_en[k][id] != 0 && m_mode[k][id] == 2) begin
            d = y - m_y0[k][id];
            if (d < 0) d = -d;
            if (d <= m_w[k][id]) begin
                e = m_w[k][id] - d;
                emp = 1'b0;
                s = m_x0[k][id] - e;
                if (s < 0) s = 0;
                t = m_x0[k][id] + e;
                if (t > CMAX) t = CMAX;
            end
        end
    endfunction

    function automatic void build(input int k, input int y);
        bit    emp;
        int    s, t;
        beat_t b;
        for (int id = 0; id < 4; id++) begin
            model_iv(k, id, y, emp, s, t);
            if (!emp || k == 1 || id == 3) begin
                b.id = id; b.s = s; b.t = t; b.last = (id == 3) ? 1 : 0;
                exq[k].push_back(b);
            end
        end
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin : per_dut
            bit    was_busy;
            beat_t hd;
            if (rst) begin
                chk($sformatf("ready_in_reset[%0d]", k), int'(req_ready_v[k]), 0);
                exq[k].delete();
                mbusy[k] = 1'b0;
                hold[k]  = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    m_en[k][i] = 0; m_mode[k][i] = 0; m_x0[k][i] = 0;
                    m_y0[k][i] = 0; m_w[k][i] = 0; m_h[k][i] = 0;
                end
            end else begin
                was_busy = mbusy[k];
                chk($sformatf("req_ready[%0d]", k), int'(req_ready_v[k]), was_busy ? 0 : 1);
                chk($sformatf("busy[%0d]", k), int'(busy_v[k]), was_busy ? 1 : 0);
                if (out_valid_v[k]) begin
                    if (hold[k]) begin
                        chk($sformatf("stable_s[%0d]", k), int'(out_s_v[k]), held[k].s);
                        chk($sformatf("stable_t[%0d]", k), int'(out_t_v[k]), held[k].t);
                        chk($sformatf("stable_id[%0d]", k), int'(out_id_v[k]), held[k].id);
                    end
                    if (exq[k].size() == 0) begin
                        chk($sformatf("unexpected_beat[%0d]", k), 1, 0);
                    end else begin
                        hd = exq[k][0];
                        chk($sformatf("out_id[%0d]", k), int'(out_id_v[k]), hd.id);
                        chk($sformatf("out_s[%0d]", k), int'(out_s_v[k]), hd.s);
                        chk($sformatf("out_t[%0d]", k), int'(out_t_v[k]), hd.t);
                        chk($sformatf("out_last[%0d]", k), int'(out_last_v[k]), hd.last);
                    end
                    hd.id = int'(out_id_v[k]); hd.s = int'(out_s_v[k]);
                    hd.t = int'(out_t_v[k]);   hd.last = int'(out_last_v[k]);
                    if (out_ready) begin
                        logq[k].push_back(hd);
                        if (exq[k].size() > 0) begin
                            if (exq[k][0].last != 0) mbusy[k] = 1'b0;
                            void'(exq[k].pop_front());
                        end
                        hold[k] = 1'b0;
                    end else begin
                        hold[k] = 1'b1;
                        held[k] = hd;
                    end
                end else begin
                    if (hold[k]) chk($sformatf("valid_dropped[%0d]", k), 0, 1);
                    hold[k] = 1'b0;
                end
                if (cfg_we && !was_busy) begin
                    m_en[k][cfg_id] = int'(cfg_en);  m_mode[k][cfg_id] = int'(cfg_mode);
                    m_x0[k][cfg_id] = int'(cfg_x0);  m_y0[k][cfg_id]   = int'(cfg_y0);
                    m_w[k][cfg_id]  = int'(cfg_w);   m_h[k][cfg_id]    = int'(cfg_h);
                end
                if (req_valid && !was_busy) begin
                    build(k, int'(req_y));
                    mbusy[k] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int id, input int en, input int mode, input int x0,
                           input int y0, input int w, input int h);
        cfg_id = 2'(id); cfg_en = 1'(en); cfg_mode = 2'(mode);
        cfg_x0 = 9'(x0); cfg_y0 = 9'(y0); cfg_w = 9'(w); cfg_h = 9'(h);
    endtask

    task automatic cfg(input int id, input int en, input int mode, input int x0,
                       input int y0, input int w, input int h);
        set_cfg(id, en, mode, x0, y0, w, h);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic req(input int y);
        logq[0].delete();
        logq[1].delete();
        req_valid = 1'b1;
        req_y = 9'(y);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy_v[0] && !busy_v[1] && exq[0].size() == 0 && exq[1].size() == 0)
                done = 1'b1;
        end
        chk("idle_timeout", int'(done), 1);
        tick();
    endtask

    task automatic wait_valid();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (out_valid_v[0]) done = 1'b1;
        end
        chk("valid_timeout", int'(done), 1);
        tick();
    endtask

    task automatic scan(input int y);
        req(y);
        wait_idle();
    endtask

    task automatic chk_len(input int k, input int n);
        chk($sformatf("beat_count[%0d]", k), logq[k].size(), n);
    endtask

    task automatic chk_beat(input int k, input int i, input int id, input int s,
                            input int t, input int last);
        if (i >= logq[k].size()) begin
            chk($sformatf("beat_missing[%0d].%0d", k, i), logq[k].size(), i + 1);
        end else begin
            chk($sformatf("lit_id[%0d].%0d", k, i), logq[k][i].id, id);
            chk($sformatf("lit_s[%0d].%0d", k, i), logq[k][i].s, s);
            chk($sformatf("lit_t[%0d].%0d", k, i), logq[k][i].t, t);
            chk($sformatf("lit_last[%0d].%0d", k, i), logq[k][i].last, last);
        end
    endtask

    task automatic expect_one(input int id, input int s, input int t);
        chk_len(0, 2);
        chk_beat(0, 0, id, s, t, 0);
        chk_beat(0, 1, 3, 1, 0, 1);
    endtask

    task automatic expect_empty();
        chk_len(0, 1);
        chk_beat(0, 0, 3, 1, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; req_valid = 1'b0; out_ready = 1'b1; req_y = 9'd0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", int'(out_valid_v[k]), 0);
            chk("rst_out_last", int'(out_last_v[k]), 0);
            chk("rst_out_id", int'(out_id_v[k]), 0);
            chk("rst_out_s", int'(out_s_v[k]), 1);
            chk("rst_out_t", int'(out_t_v[k]), 0);
            chk("rst_busy", int'(busy_v[k]), 0);
            chk("rst_req_ready", int'(req_ready_v[k]), 1);
        end
        tick();

        cfg(0, 1, 0, 10, 20, 5, 0);
        scan(22); expect_one(0, 10, 15);
        chk_len(1, 4);
        chk_beat(1, 0, 0, 10, 15, 0);
        chk_beat(1, 1, 1, 1, 0, 0);
        chk_beat(1, 2, 2, 1, 0, 0);
        chk_beat(1, 3, 3, 1, 0, 1);
        scan(19); expect_empty();
        scan(26); expect_empty();
        scan(20); expect_one(0, 10, 15);
        scan(25); expect_one(0, 10, 15);

        cfg(1, 1, 2, 100, 50, 10, 0);
        scan(53); expect_one(1, 93, 107);
        scan(60); expect_one(1, 100, 100);
        scan(40); expect_one(1, 100, 100);
        scan(61); expect_empty();

        cfg(2, 1, 1, 500, 0, 20, 3);
        scan(2); expect_one(2, 500, 511);
        cfg(3, 1, 2, 3, 50, 10, 0);
        scan(50);
        chk_len(0, 2);
        chk_beat(0, 0, 1, 90, 110, 0);
        chk_beat(0, 1, 3, 0, 13, 1);
        cfg(0, 1, 0, 0, 505, 20, 0);
        scan(511); expect_one(0, 0, 20);

        cfg(2, 1, 3, 0, 0, 100, 100);
        scan(2); expect_empty();

        // write and request in the same cycle: the new entry is seen by this scan
        set_cfg(2, 1, 0, 30, 0, 4, 0);
        cfg_we = 1'b1;
        req(3);
        cfg_we = 1'b0;
        wait_idle();
        expect_one(2, 30, 34);

        // backpressure on the first beat, with a write attempted mid-scan
        out_ready = 1'b0;
        req(511);
        wait_valid();
        cfg(0, 1, 0, 7, 0, 9, 0);
        repeat (3) tick();
        out_ready = 1'b1;
        wait_idle();
        expect_one(0, 0, 20);
        scan(511); expect_one(0, 0, 20);

        // reset in the middle of a held beat abandons the scan and clears the table
        out_ready = 1'b0;
        req(511);
        wait_valid();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", int'(req_ready_v[0]), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", int'(out_valid_v[0]), 0);
        chk("post_rst_req_ready", int'(req_ready_v[0]), 1);
        chk("post_rst_busy", int'(busy_v[0]), 0);
        chk("post_rst_logged", logq[0].size(), 0);
        out_ready = 1'b1;
        tick();
        scan(511); expect_empty();
        chk_len(1, 4);
        chk_beat(1, 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interval_shape_scan.md
# interval_shape_scan

Sequential, parametrised interval generator for the render pipeline. It holds a table of `NSHAPE` shape descriptors: axis square, axis rectangle, or 45°-rotated square (diamond). For each requested scan line `y` it streams one horizontal interval `[s, t]` per shape over a valid/ready handshake. The raster stage uses these intervals to fill pixels, and coordinate arithmetic saturates instead of wrapping.

## Interface
- `CORDW`, 9, coordinate width.
- `NSHAPE`, 8, descriptor table depth (≥2).
- `IDW`, `$clog2(NSHAPE)`, shape index width.
- `SKIP_EMPTY`, 1, when 1 suppress empty/disabled beats except the final one.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  descriptor write strobe.
- `cfg_id`  in  IDW  descriptor index.
- `cfg_en`  in  1  shape enable.
- `cfg_mode`  in  2  0 square, 1 rectangle, 2 diamond, 3 reserved (treated as disabled).
- `cfg_x0`, `cfg_y0`  in  CORDW  corner (modes 0/1) or centre (mode 2).
- `cfg_w`  in  CORDW  edge/width (0/1) or half-diagonal r (2).
- `cfg_h`  in  CORDW  height (mode 1 only).
- `req_valid`  in  1 / `req_ready`  out  1 / `req_y`  in  CORDW  line request.
- `out_valid`  out  1 / `out_ready`  in  1  result handshake.
- `out_id`  out  IDW, `out_s`  out  CORDW, `out_t`  out  CORDW, `out_last`  out  1.
- `busy`  out  1  scan in progress.

## Operation
- Table: per entry en, mode, x0, y0, w, h registers. Reset clears all fields to 0, so all shapes are disabled.
- `cfg_we` writes entry `cfg_id` when `busy=0`. `cfg_we` is ignored while `busy=1`.
- FSM states are IDLE, EVAL and EMIT.
- IDLE: `req_ready=1`. When `req_valid & req_ready`, latch `req_y` into `y_q`, set idx=0 and go to EVAL.
- EVAL: compute the interval of entry idx against `y_q`.
  - If the entry is disabled or empty, `SKIP_EMPTY=1` and idx≠NSHAPE-1: idx++ and stay in EVAL.
  - Otherwise register the result into the out regs and go to EMIT.
- EMIT: `out_valid=1` and hold.
  - On `out_valid & out_ready`: if idx=NSHAPE-1 go to IDLE, else idx++ and go to EVAL.
- `out_last=1` only on the beat with `out_id=NSHAPE-1`. That beat is always emitted; a disabled or empty final entry carries the empty interval.
- Empty interval encoding: s=1, t=0.
- Arithmetic: all sums are computed at CORDW+1 bits. Results ≥2^CORDW saturate to 2^CORDW-1; differences <0 clamp to 0.
- Mode 0 (square): the line is in range iff y0 ≤ y ≤ y0+w. In range gives s=x0, t=sat(x0+w). Bounds are inclusive.
- Mode 1 (rectangle): same as mode 0, but the vertical range is y0 ≤ y ≤ y0+h.
- Mode 2 (diamond): with d=|y−y0|, the line is empty iff d>w. Otherwise, with e=w−d, s=clamp0(x0−e) and t=sat(x0+e).
- If y0+w or y0+h saturates, the vertical bound is 2^CORDW−1.
- `busy = (state≠IDLE)`.

## Timing
- Reset values: `req_ready=0` during the reset cycle and 1 afterwards. `out_valid=0`, `out_last=0`, `out_id=0`, `out_s=1`, `out_t=0`, `busy=0`, state=IDLE.
- Request accepted at edge N; state is EVAL in cycle N+1. The first `out_valid` is high at N+2 at the earliest.
- Each skipped entry costs 1 cycle. Each emitted beat costs ≥2 cycles (EVAL and EMIT).
- Worst-case scan with `out_ready` held high: 2·NSHAPE cycles after acceptance.
- While `out_valid=1 & out_ready=0`, all `out_*` values are stable.
- `req_ready=0` from acceptance until the cycle after the `out_last` handshake.
- A `cfg_we` in the same cycle as request acceptance is applied, because `busy` is still 0.
- `rst` asserted in any state: the next cycle shows the reset values, the table is cleared and the scan is abandoned. No `out_last` is produced for the abandoned scan.

## Test plan
- NSHAPE=4, CORDW=9, SKIP_EMPTY=1. Load entry 0 as mode 0, (10,20), w=5; entries 1–3 disabled. Request y=22 -> beats (id0, 10, 15, last=0), then (id3, 1, 0, last=1).
- Same setup, requests y=19 and y=26 -> only (id3, 1, 0, last=1). Requests y=20 and y=25 -> (id0, 10, 15) each.
- Diamond entry 1: centre (100,50), r=10. y=53 -> (93, 107); y=60 -> (100, 100); y=40 -> (100, 100); y=61 -> skipped.
- Saturation cases:
  - Rectangle at (500,0), w=20, h=3, y=2 -> (500, 511).
  - Diamond at (3,50), r=10, y=50 -> (0, 13).
  - Square at y0=505, w=20, y=511 -> in range.
- Backpressure: hold `out_ready=0` for 5 cycles on the first beat -> `out_*` stable, `req_ready=0`, and a `cfg_we` during the scan leaves the table unchanged. SKIP_EMPTY=0 -> 4 beats with ids 0–3 in order.
- Assert `rst` during EMIT -> next cycle `out_valid=0`, `req_ready=1`, `busy=0`. A following request returns only (id3, 1, 0, last=1) because the table is cleared.
